// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file with scoreboard.
package regfile_mp_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

  // A write or issue takes effect unless it targets the hardwired zero register.
  function automatic logic isEffective(input logic en, input int addr, input int zeroReg);
    return en && !(zeroReg != 0 && addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode-side bundle: read ports, writeback ports, issue strobe and scoreboard outputs.
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic [NREG-1:0]          busy_vec;
  logic                     wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec, wr_conflict
  );
endinterface

// File: rtl/regfile_mp_sb_bypass.sv
// Per-read-port forwarding mux: picks the highest-index effective write port
// whose address matches this read port.
module rf_bypass_mux #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [NWR-1:0]           wrEff,
  input  logic [NWR-1:0][AW-1:0]   wrAddr,
  input  logic [NWR-1:0][XLEN-1:0] wrData,
  input  logic [AW-1:0]            rdAddr,
  output logic                     hit,
  output logic [XLEN-1:0]          data
);

  // Ascending scan so later (higher-priority) ports overwrite earlier matches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < NWR; k++) begin
      if (wrEff[k] && wrAddr[k] == rdAddr) begin
        hit  = 1'b1;
        data = wrData[k];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write bypass, per-register pending
// bits for the hazard unit, and a registered write-collision flag.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           reset,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic [NREG-1:0]           busyNext;
  logic [NWR-1:0]            wrEff;
  logic                      issEff;
  logic                      conflictNext;
  logic                      conflict;

  // Qualify writes and issue against the zero register before anything else sees them.
  always_comb begin
    wrEff = '0;
    for (int k = 0; k < NWR; k++)
      wrEff[k] = isEffective(bus.wr_en[k], int'(bus.wr_addr[k]), ZERO_REG);
    issEff = isEffective(bus.iss_en, int'(bus.iss_addr), ZERO_REG);
  end

  // Storage update; ascending port order makes the highest index win a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wrEff[k]) regs[wrAddr(k)] <= bus.wr_data[k];
    end
  end

  function automatic logic [AW-1:0] wrAddr(input int k);
    return bus.wr_addr[k];
  endfunction

  // Writeback clears pending, issue sets it last so a new producer beats an old one.
  always_comb begin
    busyNext = busy;
    for (int k = 0; k < NWR; k++)
      if (wrEff[k]) busyNext[bus.wr_addr[k]] = 1'b0;
    if (issEff) busyNext[bus.iss_addr] = 1'b1;
  end

  // Pending-bit register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busyNext;
  end

  // Flag any pair of effective write ports aiming at the same register.
  always_comb begin
    conflictNext = 1'b0;
    for (int j = 0; j < NWR; j++)
      for (int k = j + 1; k < NWR; k++)
        if (wrEff[j] && wrEff[k] && bus.wr_addr[j] == bus.wr_addr[k])
          conflictNext = 1'b1;
  end

  // Collision flag is a one-cycle pulse after the offending write.
  always_ff @(posedge clk) begin
    if (reset) conflict <= 1'b0;
    else       conflict <= conflictNext;
  end

  assign bus.busy_vec    = busy;
  assign bus.wr_conflict = conflict;

  // One forwarding mux per read port; bypass also masks the pending bit.
  for (genvar i = 0; i < NRD; i++) begin : gRd
    logic            hit;
    logic [XLEN-1:0] fwd;
    logic [AW-1:0]   addr;
    logic            isZero;

    assign addr   = bus.rd_addr[i];
    assign isZero = (ZERO_REG != 0) && (int'(addr) == REG_ZERO);

    rf_bypass_mux #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) uMux (
      .wrEff  (wrEff),
      .wrAddr (bus.wr_addr),
      .wrData (bus.wr_data),
      .rdAddr (addr),
      .hit    (hit),
      .data   (fwd)
    );

    assign bus.rd_data[i] = hit ? fwd : (isZero ? '0 : regs[addr]);
    assign bus.rd_busy[i] = busy[addr] & ~hit;
  end

endmodule
